regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//   Parametrised register file with REGS entries of WIDTH bits each.
//   It generalises the fixed-width 32-bit and 12-bit enable/clear registers into an addressed array.
//   It provides two asynchronous read ports and one synchronous write port.
//   A per-entry pending (scoreboard) bit supports pipeline hazard detection.
//   Sits between decode (reads, marks) and writeback (writes) in the Simple_Processor datapath.
// PARAMETERS
//   WIDTH   32  data bits per register
//   ADDR_W  5   address bits; REGS = 2**ADDR_W entries
//   ZERO_R0 1   1: entry 0 reads as 0, ignores writes/marks, never pending
//   BYPASS  1   1: read of the address being written this cycle returns wr_data
// PORTS
//   clk       in   1       clock; all state updates on rising edge
//   clr       in   1       synchronous active-high reset
//   wr_en     in   1       write strobe
//   wr_addr   in   ADDR_W  write address
//   wr_data   in   WIDTH   write data
//   mark_en   in   1       set pending bit of mark_addr (producer issued)
//   mark_addr in   ADDR_W  entry to mark pending
//   rd_addr_a in   ADDR_W  read port A address
//   rd_addr_b in   ADDR_W  read port B address
//   rd_data_a out  WIDTH   read port A data
//   rd_data_b out  WIDTH   read port B data
//   pend_a    out  1       pending bit of rd_addr_a
//   pend_b    out  1       pending bit of rd_addr_b
//   pend_any  out  1       OR of all pending bits
// BEHAVIOUR
//   - Reset: clr=1 at rising edge -> every entry = 0, every pending bit = 0.
//     After reset, rd_data_* = 0 and pend_* = 0.
//     clr overrides wr_en/mark_en in the same cycle; reset mid-sequence discards in-flight marks.
//   - Write: wr_en=1 at rising edge -> entry[wr_addr] <= wr_data; visible in storage next cycle.
//     Same edge clears pending[wr_addr].
//   - Mark: mark_en=1 at rising edge -> pending[mark_addr] <= 1.
//   - Simultaneous write and mark to the same address: mark wins.
//     Data is written and pending ends at 1 (newer producer outstanding).
//   - Reads: combinational, zero latency.
//     rd_data_x = entry[rd_addr_x], or wr_data when BYPASS=1 && wr_en && wr_addr==rd_addr_x.
//     pend_x = pending[rd_addr_x], forced 0 when BYPASS=1 and the bypass condition holds
//     without a same-address mark.
//     Both ports may read the same address; each port is independent.
//   - BYPASS=0: a read during the write cycle returns the old value; the new value appears the next cycle.
//   - ZERO_R0=1: address 0 always reads 0 with pend 0; writes and marks to 0 have no effect (including bypass).
//   - ZERO_R0=0: entry 0 behaves as any other entry.
//   - Width: wr_data stored unmodified; no sign/zero extension; addresses are never out of range (REGS = 2**ADDR_W).
//   - pend_any is combinational from registered pending bits (reflects state after last edge).
// TESTING
//   1. Assert clr 1 cycle after random writes -> all 32 entries read 0, pend_any=0.
//   2. Write 0xDEADBEEF to r5, then read A=5, B=5 next cycle -> both 0xDEADBEEF.
//   3. BYPASS=1: wr r7=0x1234 while reading A=7 same cycle -> rd_data_a=0x1234.
//      BYPASS=0 -> old value, then 0x1234 next cycle.
//   4. Write 0xFFFFFFFF to r0 with ZERO_R0=1 -> rd_data_a(0)=0.
//      Mark r0 -> pend_a=0, pend_any=0.
//   5. Mark r3 -> pend_a(3)=1, pend_any=1.
//      Then write r3=0x55 with mark r3 same cycle -> pend stays 1.
//      Then write r3=0x66 alone -> pend 0, data 0x66.
//   6. Mark r9, assert clr with wr_en to r9=0xAA same cycle -> r9=0, pend 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two asynchronous read ports,
// one synchronous write port, and a per-entry pending (scoreboard) bit for
// pipeline hazard detection. Decode reads and marks; writeback writes.
module regfile_sb #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              pend_a,
    output logic              pend_b,
    output logic              pend_any
);

    localparam int REGS = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem_q  [REGS];
    logic [WIDTH-1:0]  mem_d  [REGS];
    logic [REGS-1:0]   pend_q;
    logic [REGS-1:0]   pend_d;

    logic              wr_ok;
    logic              mark_ok;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [WIDTH-1:0]  rd_data [2];
    logic              rd_pend [2];

    // Entry 0 is hardwired when ZERO_R0 is set, so writes and marks to it are dropped.
    assign wr_ok   = wr_en   && !((ZERO_R0 != 0) && (wr_addr   == '0));
    assign mark_ok = mark_en && !((ZERO_R0 != 0) && (mark_addr == '0));

    // Next state: a write stores data and retires the pending bit; a mark re-arms it.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        // NOTE: the mark is applied after the write in this blocking sequence, so a
        // same-address write+mark leaves pending set (the newer producer wins).
        if (mark_ok) begin
            pend_d[mark_addr] = 1'b1;
        end
    end

    // State update with synchronous clear overriding writes and marks.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately reset, because clr must zero every
        // entry; this keeps it in flops rather than an inferred RAM macro.
        if (clr) begin
            for (int i = 0; i < REGS; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q <= pend_d;
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    // Combinational read ports with optional write bypass and entry-0 forcing.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            rd_pend[p] = pend_q[rd_addr[p]];
            if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr[p])) begin
                rd_data[p] = wr_data;
                // The write retires the hazard unless a newer producer marks it now.
                if (!(mark_en && (mark_addr == rd_addr[p]))) begin
                    rd_pend[p] = 1'b0;
                end
            end
            if ((ZERO_R0 != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_pend[p] = 1'b0;
            end
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];
    assign pend_a    = rd_pend[0];
    assign pend_b    = rd_pend[1];

    // Aggregate hazard flag from registered state only.
    assign pend_any  = |pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two register files from shared inputs -- one with
// ZERO_R0=1/BYPASS=1 (instance 0) and one with ZERO_R0=0/BYPASS=0 (instance 1) --
// and compares both against an array-based reference model every cycle.
module tb_regfile_sb;

    logic        clk;
    logic        clr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mark_en;
    logic [4:0]  mark_addr;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;

    logic [31:0] rda0, rdb0, rda1, rdb1;
    logic        pa0, pb0, pany0, pa1, pb1, pany1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: [instance][entry].
    bit [31:0] m_mem  [2][32];
    bit        m_pend [2][32];

    regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) u_dut (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_en(mark_en), .mark_addr(mark_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda0), .rd_data_b(rdb0), .pend_a(pa0), .pend_b(pb0), .pend_any(pany0)
    );

    regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_R0(0), .BYPASS(0)) u_dut_nb (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_en(mark_en), .mark_addr(mark_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda1), .rd_data_b(rdb1), .pend_a(pa1), .pend_b(pb1), .pend_any(pany1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instance 0 has the zero register and bypass; instance 1 has neither.
    function automatic bit [31:0] exp_data(input int k, input bit [4:0] a);
        if (k == 0 && a == 0) return 32'h0;
        if (k == 0 && wr_en && wr_addr == a) return wr_data;
        return m_mem[k][a];
    endfunction

    function automatic bit exp_pend(input int k, input bit [4:0] a);
        if (k == 0 && a == 0) return 1'b0;
        if (k == 0 && wr_en && wr_addr == a && !(mark_en && mark_addr == a)) return 1'b0;
        return m_pend[k][a];
    endfunction

    function automatic bit exp_any(input int k);
        bit r = 1'b0;
        for (int i = 0; i < 32; i++) r |= m_pend[k][i];
        return r;
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = 32'h0;
                    m_pend[k][i] = 1'b0;
                end
            end else begin
                if (wr_en && !(k == 0 && wr_addr == 0)) begin
                    m_mem[k][wr_addr]  = wr_data;
                    m_pend[k][wr_addr] = 1'b0;
                end
                if (mark_en && !(k == 0 && mark_addr == 0)) m_pend[k][mark_addr] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check($sformatf("i0 rd_a[%0d]", rd_addr_a), rda0, exp_data(0, rd_addr_a));
        check($sformatf("i0 rd_b[%0d]", rd_addr_b), rdb0, exp_data(0, rd_addr_b));
        check($sformatf("i0 pend_a[%0d]", rd_addr_a), {31'b0, pa0}, {31'b0, exp_pend(0, rd_addr_a)});
        check($sformatf("i0 pend_b[%0d]", rd_addr_b), {31'b0, pb0}, {31'b0, exp_pend(0, rd_addr_b)});
        check("i0 pend_any", {31'b0, pany0}, {31'b0, exp_any(0)});
        check($sformatf("i1 rd_a[%0d]", rd_addr_a), rda1, exp_data(1, rd_addr_a));
        check($sformatf("i1 rd_b[%0d]", rd_addr_b), rdb1, exp_data(1, rd_addr_b));
        check($sformatf("i1 pend_a[%0d]", rd_addr_a), {31'b0, pa1}, {31'b0, exp_pend(1, rd_addr_a)});
        check($sformatf("i1 pend_b[%0d]", rd_addr_b), {31'b0, pb1}, {31'b0, exp_pend(1, rd_addr_b)});
        check("i1 pend_any", {31'b0, pany1}, {31'b0, exp_any(1)});
    endtask

    // Inputs are always driven just after a rising edge; outputs are sampled at the
    // falling edge; the model advances on the rising edge.
    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input bit [4:0] a, input bit [4:0] b);
        clr = 1'b0; wr_en = 1'b0; mark_en = 1'b0;
        rd_addr_a = a; rd_addr_b = b;
    endtask

    task automatic rand_cycle(input int clr_one_in);
        clr       = (clr_one_in > 0) && ($urandom_range(0, clr_one_in - 1) == 0);
        wr_en     = 1'($urandom_range(0, 1));
        wr_addr   = 5'($urandom);
        wr_data   = $urandom;
        mark_en   = ($urandom_range(0, 3) == 0);
        mark_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
        rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
        rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 5'($urandom);
        settle();
        tick();
    endtask

    initial begin
        // Power-up reset.
        clr = 1'b1; wr_en = 1'b0; mark_en = 1'b0;
        wr_addr = '0; wr_data = '0; mark_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
        tick();
        idle(5'd0, 5'd31);
        settle();
        check("reset rd_b", rdb0, 32'h0);
        check("reset pend_any", {31'b0, pany0}, 32'h0);
        tick();

        // Random traffic to populate entries and pending bits.
        repeat (40) rand_cycle(0);

        // 1: clear with a concurrent random write, then scan all entries.
        rand_cycle(0);
        clr = 1'b1; wr_en = 1'b1; mark_en = 1'b1;
        settle();
        tick();
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            settle();
            check($sformatf("t1 i0 entry %0d", i), rda0, 32'h0);
            check($sformatf("t1 i1 entry %0d", i), rda1, 32'h0);
            tick();
        end
        check("t1 i0 pend_any", {31'b0, pany0}, 32'h0);

        // 2: write r5, read on both ports next cycle.
        idle(5'd5, 5'd5);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        settle();
        tick();
        idle(5'd5, 5'd5);
        settle();
        check("t2 i0 a", rda0, 32'hDEADBEEF);
        check("t2 i0 b", rdb0, 32'hDEADBEEF);
        check("t2 i1 a", rda1, 32'hDEADBEEF);
        check("t2 i1 b", rdb1, 32'hDEADBEEF);
        tick();

        // 3: bypass versus no bypass on r7.
        idle(5'd7, 5'd5);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000ABCD;
        settle();
        tick();
        idle(5'd7, 5'd7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00001234;
        settle();
        check("t3 i0 bypass", rda0, 32'h00001234);
        check("t3 i1 old", rda1, 32'h0000ABCD);
        tick();
        idle(5'd7, 5'd7);
        settle();
        check("t3 i1 next", rda1, 32'h00001234);
        tick();

        // 4: r0 is hardwired in instance 0, ordinary in instance 1.
        idle(5'd0, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        settle();
        check("t4 i0 r0 same cycle", rda0, 32'h0);
        tick();
        idle(5'd0, 5'd0);
        mark_en = 1'b1; mark_addr = 5'd0;
        settle();
        check("t4 i0 r0 after write", rda0, 32'h0);
        check("t4 i1 r0 after write", rda1, 32'hFFFFFFFF);
        tick();
        idle(5'd0, 5'd0);
        settle();
        check("t4 i0 pend r0", {31'b0, pa0}, 32'h0);
        check("t4 i0 pend_any", {31'b0, pany0}, 32'h0);
        check("t4 i1 pend r0", {31'b0, pa1}, 32'h1);
        tick();

        // 5: mark r3, write+mark r3, then plain write r3.
        idle(5'd3, 5'd3);
        mark_en = 1'b1; mark_addr = 5'd3;
        settle();
        tick();
        idle(5'd3, 5'd3);
        settle();
        check("t5 pend after mark", {31'b0, pa0}, 32'h1);
        check("t5 pend_any", {31'b0, pany0}, 32'h1);
        tick();
        idle(5'd3, 5'd3);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        mark_en = 1'b1; mark_addr = 5'd3;
        settle();
        check("t5 pend write+mark bypass", {31'b0, pa0}, 32'h1);
        tick();
        idle(5'd3, 5'd3);
        settle();
        check("t5 pend after write+mark", {31'b0, pa0}, 32'h1);
        check("t5 data 55", rda0, 32'h55);
        tick();
        idle(5'd3, 5'd3);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66;
        settle();
        check("t5 pend bypass cleared", {31'b0, pa0}, 32'h0);
        tick();
        idle(5'd3, 5'd3);
        settle();
        check("t5 pend after write", {31'b0, pa0}, 32'h0);
        check("t5 i0 data 66", rda0, 32'h66);
        check("t5 i1 data 66", rda1, 32'h66);
        tick();

        // 6: clear overrides a same-cycle write and mark.
        idle(5'd9, 5'd9);
        mark_en = 1'b1; mark_addr = 5'd9;
        settle();
        tick();
        idle(5'd9, 5'd9);
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
        mark_en = 1'b1; mark_addr = 5'd9;
        settle();
        tick();
        idle(5'd9, 5'd9);
        settle();
        check("t6 i0 r9", rda0, 32'h0);
        check("t6 i0 pend r9", {31'b0, pa0}, 32'h0);
        check("t6 i0 pend_any", {31'b0, pany0}, 32'h0);
        check("t6 i1 pend_any", {31'b0, pany1}, 32'h0);
        tick();

        // Long random run with occasional clears.
        repeat (300) rand_cycle(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
